// File: rtl/alu_rs_scheduler.sv
// Reservation station for the integer ALU: holds dispatched ops, captures operands
// from the CDB and issues the lowest-index ready entry, one per cycle.
module alu_rs_scheduler #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             disp_valid,
  input  logic [5:0]       disp_opcode,
  input  logic [31:0]      disp_imm,
  input  logic [31:0]      disp_pc,
  input  logic [ROB_W-1:0] disp_rob,
  input  logic [31:0]      disp_vj,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic             disp_rj,
  input  logic [31:0]      disp_vk,
  input  logic [ROB_W-1:0] disp_qk,
  input  logic             disp_rk,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_rob,
  input  logic [31:0]      cdb_value,
  output logic             issue_sgn,
  output logic [5:0]       issue_opcode,
  output logic [31:0]      issue_lhs,
  output logic [31:0]      issue_rhs,
  output logic [31:0]      issue_imm,
  output logic [31:0]      issue_pc,
  output logic [ROB_W-1:0] issue_rob
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] rj;
  logic [DEPTH-1:0] rk;
  logic [5:0]       opcode [DEPTH];
  logic [31:0]      imm    [DEPTH];
  logic [31:0]      pc     [DEPTH];
  logic [ROB_W-1:0] rob    [DEPTH];
  logic [31:0]      vj     [DEPTH];
  logic [ROB_W-1:0] qj     [DEPTH];
  logic [31:0]      vk     [DEPTH];
  logic [ROB_W-1:0] qk     [DEPTH];

  logic             sel_vld_p0;
  logic [IDX_W-1:0] sel_idx_p0;
  logic [IDX_W-1:0] free_idx;
  logic             accept;
  logic             snoop_j;
  logic             snoop_k;

  assign full    = &valid;
  assign accept  = disp_valid && !full;
  assign snoop_j = !disp_rj && cdb_valid && (cdb_rob == disp_qj);
  assign snoop_k = !disp_rk && cdb_valid && (cdb_rob == disp_qk);

  // Select stage: decided purely from registered entry state
  always_comb begin
    sel_vld_p0 = 1'b0;
    sel_idx_p0 = '0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && rj[i] && rk[i]) begin
        sel_vld_p0 = 1'b1;
        sel_idx_p0 = IDX_W'(i);
      end
      if (!valid[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  // Issue stage: registered ALU bus and entry occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid        <= '0;
      issue_sgn    <= 1'b0;
      issue_opcode <= '0;
      issue_lhs    <= '0;
      issue_rhs    <= '0;
      issue_imm    <= '0;
      issue_pc     <= '0;
      issue_rob    <= '0;
    end else if (rdy) begin
      if (clear) begin
        valid     <= '0;
        issue_sgn <= 1'b0;
      end else begin
        issue_sgn <= sel_vld_p0;
        if (sel_vld_p0) begin
          valid[sel_idx_p0] <= 1'b0;
          issue_opcode      <= opcode[sel_idx_p0];
          issue_lhs         <= vj[sel_idx_p0];
          issue_rhs         <= vk[sel_idx_p0];
          issue_imm         <= imm[sel_idx_p0];
          issue_pc          <= pc[sel_idx_p0];
          issue_rob         <= rob[sel_idx_p0];
        end
        // The freed winner and the free slot are always different entries
        if (accept) begin
          valid[free_idx] <= 1'b1;
        end
      end
    end
  end

  // Entry payload: only meaningful while the matching valid bit is set
  always_ff @(posedge clk) begin
    if (rdy && !clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && !rj[i] && cdb_valid && (qj[i] == cdb_rob)) begin
          vj[i] <= cdb_value;
          rj[i] <= 1'b1;
        end
        if (valid[i] && !rk[i] && cdb_valid && (qk[i] == cdb_rob)) begin
          vk[i] <= cdb_value;
          rk[i] <= 1'b1;
        end
      end
      if (accept) begin
        opcode[free_idx] <= disp_opcode;
        imm[free_idx]    <= disp_imm;
        pc[free_idx]     <= disp_pc;
        rob[free_idx]    <= disp_rob;
        qj[free_idx]     <= disp_qj;
        qk[free_idx]     <= disp_qk;
        vj[free_idx]     <= snoop_j ? cdb_value : disp_vj;
        vk[free_idx]     <= snoop_k ? cdb_value : disp_vk;
        rj[free_idx]     <= disp_rj | snoop_j;
        rk[free_idx]     <= disp_rk | snoop_k;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler: expected issues are queued by the stimulus
// and matched in order by an independent monitor.
module tb_alu_rs_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        disp_valid = 1'b0;
  logic [5:0]  disp_opcode = '0;
  logic [31:0] disp_imm = '0;
  logic [31:0] disp_pc = '0;
  logic [3:0]  disp_rob = '0;
  logic [31:0] disp_vj = '0;
  logic [3:0]  disp_qj = '0;
  logic        disp_rj = 1'b0;
  logic [31:0] disp_vk = '0;
  logic [3:0]  disp_qk = '0;
  logic        disp_rk = 1'b0;
  logic        full;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_rob = '0;
  logic [31:0] cdb_value = '0;
  logic        issue_sgn;
  logic [5:0]  issue_opcode;
  logic [31:0] issue_lhs;
  logic [31:0] issue_rhs;
  logic [31:0] issue_imm;
  logic [31:0] issue_pc;
  logic [3:0]  issue_rob;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  rob;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic edge_rdy;

  alu_rs_scheduler #(.DEPTH(8), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .disp_valid(disp_valid), .disp_opcode(disp_opcode), .disp_imm(disp_imm),
    .disp_pc(disp_pc), .disp_rob(disp_rob), .disp_vj(disp_vj), .disp_qj(disp_qj),
    .disp_rj(disp_rj), .disp_vk(disp_vk), .disp_qk(disp_qk), .disp_rk(disp_rk),
    .full(full), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .issue_sgn(issue_sgn), .issue_opcode(issue_opcode), .issue_lhs(issue_lhs),
    .issue_rhs(issue_rhs), .issue_imm(issue_imm), .issue_pc(issue_pc),
    .issue_rob(issue_rob)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] vj, input logic [3:0] qj,
                      input logic rj, input logic [31:0] vk, input logic [3:0] qk,
                      input logic rk, input logic [3:0] rob, input logic [31:0] imm,
                      input logic [31:0] pc);
    disp_valid = 1'b1; disp_opcode = op; disp_vj = vj; disp_qj = qj; disp_rj = rj;
    disp_vk = vk; disp_qk = qk; disp_rk = rk; disp_rob = rob; disp_imm = imm; disp_pc = pc;
  endtask

  task automatic cdb(input logic [3:0] rob, input logic [31:0] value);
    cdb_valid = 1'b1; cdb_rob = rob; cdb_value = value;
  endtask

  task automatic expect_issue(input logic [5:0] op, input logic [31:0] lhs,
                              input logic [31:0] rhs, input logic [31:0] imm,
                              input logic [31:0] pc, input logic [3:0] rob);
    exp_t e;
    e.op = op; e.lhs = lhs; e.rhs = rhs; e.imm = imm; e.pc = pc; e.rob = rob;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, req);
    end
  endtask

  // Monitor: a new issue is a high strobe following an enabled edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      edge_rdy = rdy;
      @(negedge clk);
      if (issue_sgn && edge_rdy && rst) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_issue got rob=%0d lhs=%h expected no issue", issue_rob, issue_lhs);
        end else begin
          e = exp_q.pop_front();
          if (issue_opcode !== e.op || issue_lhs !== e.lhs || issue_rhs !== e.rhs ||
              issue_imm !== e.imm || issue_pc !== e.pc || issue_rob !== e.rob) begin
            failures++;
            $display("FAIL issue_bus got op=%h lhs=%h rhs=%h imm=%h pc=%h rob=%0d expected op=%h lhs=%h rhs=%h imm=%h pc=%h rob=%0d",
                     issue_opcode, issue_lhs, issue_rhs, issue_imm, issue_pc, issue_rob,
                     e.op, e.lhs, e.rhs, e.imm, e.pc, e.rob);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sgn", issue_sgn, 0);
    chk("rst_full", full, 0);
    chk("rst_lhs", issue_lhs, 0);
    chk("rst_rob", issue_rob, 0);
    rst = 1'b1;
    tick();

    // 1: both operands ready, two-edge latency, one-cycle strobe
    disp(6'h01, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 1'b1, 4'd3, 32'h10, 32'h100);
    expect_issue(6'h01, 32'd5, 32'd7, 32'h10, 32'h100, 4'd3);
    tick(); idle();
    chk("t1_not_yet", issue_sgn, 0);
    chk("t1_full", full, 0);
    tick();
    chk("t1_issue", issue_sgn, 1);
    chk("t1_lhs", issue_lhs, 5);
    tick();
    chk("t1_one_cycle", issue_sgn, 0);
    chk("t1_full_after", full, 0);

    // 2: rs1 waits for CDB tag 2
    disp(6'h02, 32'd0, 4'd2, 1'b0, 32'd1, 4'd0, 1'b1, 4'd5, 32'h20, 32'h104);
    tick(); idle();
    tick();
    cdb(4'd2, 32'h10);
    chk("t2_wait", issue_sgn, 0);
    expect_issue(6'h02, 32'h10, 32'd1, 32'h20, 32'h104, 4'd5);
    tick(); idle();
    chk("t2_no_early", issue_sgn, 0);
    tick();
    chk("t2_issue", issue_sgn, 1);
    tick();

    // 3: dispatch-time snoop, then a non-matching tag
    disp(6'h03, 32'h20, 4'd0, 1'b1, 32'd0, 4'd4, 1'b0, 4'd6, 32'h30, 32'h108);
    cdb(4'd4, 32'd9);
    expect_issue(6'h03, 32'h20, 32'd9, 32'h30, 32'h108, 4'd6);
    tick(); idle();
    tick();
    chk("t3_snoop_issue", issue_sgn, 1);
    chk("t3_snoop_rhs", issue_rhs, 9);
    disp(6'h03, 32'h20, 4'd0, 1'b1, 32'd0, 4'd4, 1'b0, 4'd7, 32'h30, 32'h108);
    cdb(4'd5, 32'd9);
    tick(); idle();
    tick();
    chk("t3_nomatch", issue_sgn, 0);
    tick();
    chk("t3_still_wait", issue_sgn, 0);
    cdb(4'd4, 32'h44);
    expect_issue(6'h03, 32'h20, 32'h44, 32'h30, 32'h108, 4'd7);
    tick(); idle();
    tick();
    chk("t3_late_issue", issue_sgn, 1);
    tick();

    // 4: fill all entries; entries 2 and 5 share producer tag 10
    for (int i = 0; i < 8; i++) begin
      disp(6'h04, 32'd0, (i == 5) ? 4'd10 : 4'(8 + i), 1'b0, 32'h100 + i, 4'd0, 1'b1,
           4'(i), 32'(i), 32'h200 + 4 * i);
      if (i == 7) chk("t4_not_full_7", full, 0);
      tick();
    end
    idle();
    chk("t4_full", full, 1);
    disp(6'h05, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 1'b1, 4'd9, 32'd0, 32'd0);
    tick(); idle();
    chk("t4_full_hold", full, 1);
    cdb(4'd10, 32'hABCD);
    expect_issue(6'h04, 32'hABCD, 32'h102, 32'd2, 32'h208, 4'd2);
    expect_issue(6'h04, 32'hABCD, 32'h105, 32'd5, 32'h214, 4'd5);
    tick(); idle();
    chk("t4_full_wake", full, 1);
    tick();
    chk("t4_full_drop", full, 0);
    chk("t4_first_rob", issue_rob, 2);
    tick();
    chk("t4_second_rob", issue_rob, 5);
    tick();
    chk("t4_quiet", issue_sgn, 0);

    // 5: clear beats a pending issue, dispatch and CDB
    disp(6'h06, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1, 4'd12, 32'd0, 32'd0);
    tick();
    clear = 1'b1;
    disp(6'h06, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1, 4'd13, 32'd0, 32'd0);
    cdb(4'd8, 32'h55);
    tick(); idle();
    chk("t5_full", full, 0);
    chk("t5_sgn", issue_sgn, 0);
    cdb(4'd8, 32'd1);
    tick();
    cdb(4'd9, 32'd1);
    tick(); idle();
    tick(); tick();
    chk("t5_stay0", issue_sgn, 0);
    chk("t5_full_after", full, 0);

    // 6a: freeze while an issue is presented
    disp(6'h07, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0, 1'b1, 4'd1, 32'h70, 32'h300);
    expect_issue(6'h07, 32'h11, 32'h22, 32'h70, 32'h300, 4'd1);
    tick();
    disp(6'h08, 32'h33, 4'd0, 1'b1, 32'h44, 4'd0, 1'b1, 4'd2, 32'h80, 32'h304);
    expect_issue(6'h08, 32'h33, 32'h44, 32'h80, 32'h304, 4'd2);
    tick(); idle();
    chk("t6_p_issue", issue_rob, 1);
    rdy = 1'b0;
    disp(6'h0B, 32'd3, 4'd0, 1'b1, 32'd3, 4'd0, 1'b1, 4'd14, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_frz_sgn", issue_sgn, 1);
      chk("t6_frz_rob", issue_rob, 1);
      chk("t6_frz_lhs", issue_lhs, 32'h11);
    end
    idle();
    rdy = 1'b1;
    tick();
    chk("t6_resume_rob", issue_rob, 2);
    chk("t6_resume_sgn", issue_sgn, 1);
    tick();
    chk("t6_drop_sgn", issue_sgn, 0);
    chk("t6_hold_lhs", issue_lhs, 32'h33);

    // 6b: asynchronous reset while issuing, then while full
    disp(6'h09, 32'h99, 4'd0, 1'b1, 32'hAA, 4'd0, 1'b1, 4'd11, 32'h90, 32'h308);
    expect_issue(6'h09, 32'h99, 32'hAA, 32'h90, 32'h308, 4'd11);
    tick(); idle();
    tick();
    chk("t6_r_issue", issue_sgn, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_sgn", issue_sgn, 0);
    chk("t6_rst_lhs", issue_lhs, 0);
    chk("t6_rst_op", issue_opcode, 0);
    chk("t6_rst_rob", issue_rob, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      disp(6'h0A, 32'd0, 4'd3, 1'b0, 32'd0, 4'd0, 1'b1, 4'(i), 32'd0, 32'd0);
      tick();
    end
    idle();
    chk("t6_full_again", full, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_full", full, 0);
    @(negedge clk);
    rst = 1'b1;
    cdb(4'd3, 32'd5);
    tick(); idle();
    tick(); tick();
    chk("t6_entries_gone", issue_sgn, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
